// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver clocked from the system clock.
// Bit timing comes from an internal counter that is cleared at every sample
// point. Each bit is sampled once, at its nominal centre.
// Optional feature: define UART_RX_PARITY_EN to insert a parity bit (8E1/8O1).
// Parameter PARITY_ODD exists only in that build.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  // Terminal counts: a full bit period, and half a bit for the start-bit centre.
  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, ferr_nxt;
  logic             rx_meta, rx_s;
  logic             tc_full;

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_nxt;
  logic perr_q, perr_nxt;
`endif

  // Two-flop synchronizer; both stages reset to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tc_full = (cnt == FULL_TC);

  // Next-state and datapath decode; everything defaults to hold, strobes to 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    data_nxt  = data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_TC) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_nxt   = 3'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_nxt = 1'b0;
`endif
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (tc_full) begin
          shift_nxt[bit_idx] = rx_s;
          cnt_nxt            = '0;
          idx_nxt            = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tc_full) begin
          par_bad_nxt = (rx_s != ((^shift) ^ PARITY_ODD));
          cnt_nxt     = '0;
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (tc_full) begin
          cnt_nxt = '0;
          if (rx_s) begin
            // Leave at mid-stop-bit so a start bit right behind it is caught.
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              perr_nxt = 1'b1;
            end else begin
              data_nxt  = shift;
              valid_nxt = 1'b1;
            end
`else
            data_nxt  = shift;
            valid_nxt = 1'b1;
`endif
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= idx_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_nxt;
      perr_q    <= perr_nxt;
`endif
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + randomized bench for uart_rx at CLKS_PER_BIT=8.
// A behavioural serial driver produces frames in real time; the expected byte
// stream is kept as a queue and compared to the bytes strobed out by the DUT.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int  CPB    = 8;
  localparam real BIT_NS = 80.0;
`ifdef UART_RX_PARITY_EN
  localparam bit  PAR    = 1'b1;
`else
  localparam bit  PAR    = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Strobe monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_overlap = 0, n_long = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  logic pv = 1'b0, pf = 1'b0, pp = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(data);
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if ((valid && pv) || (frame_err && pf) || (parity_err && pp)) n_long++;
    if ((int'(valid) + int'(frame_err) + int'(parity_err)) > 1) n_overlap++;
    pv = valid; pf = frame_err; pp = parity_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Serial driver; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip, input real bit_ns);
    start_cyc = cyc;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    if (PAR) begin
      rx = (^b) ^ par_flip;
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int v0, f0, p0, lat, k;
    logic [7:0] b;

    // 1. Reset with the line toggling, then a first frame with latency check.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx = ~rx;
      chk("rst_data", data, 8'h00);
      chk("rst_strobes", {valid, frame_err, parity_err}, 3'b000);
      chk("rst_busy", busy, 1'b0);
    end
    rx = 1'b1;
    settle(2);
    rst_n = 1'b1;
    settle(4);
    @(negedge clk);
    exp_q.push_back(8'h61);
    send_frame(8'h61, 1'b1, 1'b0, BIT_NS);
    settle(2 * CPB);
    cmp_frames("first");
    lat = last_valid_cyc - (start_cyc + 1);
    chk("latency_in_79pm1", (lat >= 78 && lat <= 80), 1'b1);
    chk("valid_cleared", valid, 1'b0);

    // 2. Back-to-back frames: fixed set, then random bytes with random gaps.
    f0 = n_ferr;
    foreach (exp_q[i]) ; // queue already empty
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, 1'b0, BIT_NS);
    send_frame(8'h00, 1'b1, 1'b0, BIT_NS);
    send_frame(8'hFF, 1'b1, 1'b0, BIT_NS);
    send_frame(8'h3C, 1'b1, 1'b0, BIT_NS);
    settle(2 * CPB);
    cmp_frames("b2b");
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0, BIT_NS);
      #(BIT_NS * $urandom_range(0, 3));
    end
    settle(2 * CPB);
    cmp_frames("rand");
    chk("b2b_no_ferr", n_ferr - f0, 0);

    // 3. Glitch on the idle line.
    v0 = n_valid; f0 = n_ferr;
    @(negedge clk);
    rx = 1'b0;
    settle(2);
    rx = 1'b1;
    k = 0;
    while (busy !== 1'b0 && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("glitch_busy_drop", busy, 1'b0);
    settle(2 * CPB);
    chk("glitch_no_valid", n_valid - v0, 0);
    chk("glitch_no_ferr", n_ferr - f0, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0, BIT_NS);
    settle(2 * CPB);
    cmp_frames("post_glitch");

    // 4. Framing error followed by a held-low line.
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h81, 1'b0, 1'b0, BIT_NS);
    settle(40);
    chk("ferr_once", n_ferr - f0, 1);
    chk("ferr_no_valid", n_valid - v0, 0);
    chk("ferr_data_held", data, 8'h55);
    chk("ferr_busy_break", busy, 1'b1);
    rx = 1'b1;
    settle(6);
    chk("ferr_busy_release", busy, 1'b0);
    chk("ferr_still_once", n_ferr - f0, 1);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0, BIT_NS);
    settle(2 * CPB);
    cmp_frames("post_ferr");

    // 5. Baud-rate skew of +/-3 percent.
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 77.6);
    #(BIT_NS);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 82.4);
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0, (i % 2 == 0) ? 77.6 : 82.4);
      #(BIT_NS);
    end
    settle(2 * CPB);
    cmp_frames("skew");

    // 6. Reset during bit 4; held until the frame is over.
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    fork
      send_frame(8'h99, 1'b1, 1'b0, BIT_NS);
      begin
        #(BIT_NS * 5.5);
        @(negedge clk);
        rst_n = 1'b0;
      end
    join
    settle(4);
    chk("midrst_data", data, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    settle(2 * CPB);
    chk("midrst_no_strobe", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b0, BIT_NS);
    settle(2 * CPB);
    cmp_frames("post_rst");

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, BIT_NS);
    settle(2 * CPB);
    chk("perr_pulse", n_perr - p0, 1);
    chk("perr_no_valid", n_valid - v0, 0);
    chk("perr_data_held", data, 8'h99);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0, BIT_NS);
    settle(2 * CPB);
    cmp_frames("par_good");
`else
    chk("parity_never", n_perr, 0);
`endif

    chk("strobe_overlap", n_overlap, 0);
    chk("strobe_one_cycle", n_long, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
